stopwatch_control: RTL and testbench
====================================

STOPWATCH_CONTROL -- requirements
Module: stopwatch_control

Interface
REQ-001 SHALL have parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000, the clk frequency.
REQ-002 SHALL have parameter TICK_FREQUENCY_IN_HZ, default 100, the count-tick rate (hundredths of a second).
REQ-003 SHALL have parameter DEBOUNCE_TIME_IN_MS, default 10, the button stable time.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port btn_start_stop  input  1  raw, asynchronous, active-high push button.
REQ-007 SHALL have port btn_lap  input  1  raw, asynchronous, active-high push button.
REQ-008 SHALL have port btn_clear  input  1  raw, asynchronous, active-high push button.
REQ-009 SHALL have port number_in  input  16  live BCD count from the digit counter (4 digits x 4 bits).
REQ-010 SHALL have port count_enable  output  1  one-cycle tick that advances the counter.
REQ-011 SHALL have port count_clear  output  1  one-cycle pulse that zeroes the counter.
REQ-012 SHALL have port display_number  output  16  value for the digit display.
REQ-013 SHALL have port state  output  2  current FSM state, for the status LEDs.

Function
REQ-014 SHALL derive DEBOUNCE_CYCLES = BOARD_CLOCK_FREQUENCY_IN_HZ*DEBOUNCE_TIME_IN_MS/1000 and TICK_DIVISOR = BOARD_CLOCK_FREQUENCY_IN_HZ/TICK_FREQUENCY_IN_HZ, with DEBOUNCE_CYCLES >= 1 and TICK_DIVISOR >= 2.
REQ-015 SHALL condition each button as follows:
- 2-flop synchroniser.
- Debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
- One-cycle press pulse on each debounced 0->1 edge; no pulse on release.
REQ-016 SHALL encode states IDLE=00, RUNNING=01, PAUSED=10, LAP=11.
REQ-017 SHALL apply these transitions on press pulses:
- IDLE: start_stop->RUNNING.
- RUNNING: start_stop->PAUSED; lap->LAP.
- LAP: lap->RUNNING; start_stop->PAUSED.
- PAUSED: start_stop->RUNNING.
- Any state: clear->IDLE.
- Lap in IDLE or PAUSED is ignored.
REQ-018 SHALL, for pulses in the same cycle, give priority clear > start_stop > lap; lower-priority pulses that cycle are discarded.
REQ-019 SHALL drive count_clear high for exactly the one cycle after a clear pulse is accepted, including in IDLE.
REQ-020 SHALL run a prescaler 0..TICK_DIVISOR-1 in RUNNING and LAP:
- Holds its value in PAUSED, so resume keeps the fractional period.
- Forced to 0 in IDLE.
REQ-021 SHALL assert count_enable for one cycle each time the prescaler wraps from TICK_DIVISOR-1 to 0; never in IDLE or PAUSED.
REQ-022 SHALL register display_number as number_in with one-cycle latency in every state except LAP.
REQ-023 SHALL, on the RUNNING->LAP transition cycle, capture number_in and hold it on display_number while in LAP; counting continues underneath.
REQ-024 SHALL release display_number to the live value one cycle after LAP is left (lap, start_stop or clear).

Reset
REQ-025 SHALL, while rst is high, asynchronously force:
- state=IDLE; prescaler=0.
- count_enable=0, count_clear=0, display_number=16'h0000.
- Synchronisers, debounced levels and debounce counters to 0.
REQ-026 SHALL, on rst mid-operation (any state, mid-debounce, mid-prescale), abandon all progress; a button held through reset deasserting SHALL produce a press pulse only after a full debounce period.

Structure
REQ-027 SHALL place the state encodings and the DEBOUNCE_CYCLES/TICK_DIVISOR derivations in a shared package stopwatch_pkg.
REQ-028 SHALL implement REQ-015 in one sub-module button_conditioner (ports clk, rst, in, level, press), instantiated three times.

Verification (BOARD_CLOCK_FREQUENCY_IN_HZ=1000, DEBOUNCE_TIME_IN_MS=4 -> 4 cycles; TICK_FREQUENCY_IN_HZ=100 -> divisor 10)
REQ-029 SHALL verify debounce: start_stop toggled every 2 cycles for 20 cycles then held high -> one transition IDLE->RUNNING, 2+4+1 cycles after the final stable edge; held button gives no repeat.
REQ-030 SHALL verify ticks: RUNNING for 100 cycles -> exactly 10 count_enable pulses, spaced 10 cycles; pause at prescaler=6, resume -> first tick 4 cycles after resume.
REQ-031 SHALL verify lap freeze: number_in=16'h0123 at lap press, then ramps -> display_number holds 16'h0123 while ticks continue; second lap -> live value 1 cycle later.
REQ-032 SHALL verify priority: clear and start_stop pulses in the same cycle in RUNNING -> IDLE, one count_clear pulse, no PAUSED.
REQ-033 SHALL verify reset: rst asserted in LAP mid-prescale -> immediately state=00, display_number=0, outputs 0; after release, IDLE with no spurious pulses.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and timing derivations for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10,
    LAP     = 2'b11
  } state_t;
  function automatic int debounce_cycles(input int clk_hz, input int ms);
    return int'((longint'(clk_hz) * longint'(ms)) / longint'(1000));
  endfunction
  function automatic int tick_divisor(input int clk_hz, input int tick_hz);
    return int'(longint'(clk_hz) / longint'(tick_hz));
  endfunction
endpackage

// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and edge-detect one raw push button
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic done;
  assign done = (sync[1] != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  // accept a new level only after it has differed for the full stable window
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], in};
      cnt   <= (sync[1] == level || done) ? '0 : cnt + CW'(1);
      level <= done ? sync[1] : level;
      press <= done & sync[1];
    end
endmodule

// File: rtl/stopwatch_control.sv
// stopwatch_control: button-driven stopwatch FSM with tick prescaler and lap display freeze
import stopwatch_pkg::*;
module stopwatch_control #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int TICK_FREQUENCY_IN_HZ        = 100,
  parameter int DEBOUNCE_TIME_IN_MS         = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic [15:0] number_in,
  output logic        count_enable,
  output logic        count_clear,
  output logic [15:0] display_number,
  output logic [1:0]  state
);
  localparam int DEBOUNCE_CYCLES = debounce_cycles(BOARD_CLOCK_FREQUENCY_IN_HZ, DEBOUNCE_TIME_IN_MS);
  localparam int TICK_DIVISOR    = tick_divisor(BOARD_CLOCK_FREQUENCY_IN_HZ, TICK_FREQUENCY_IN_HZ);
  localparam int PW              = $clog2(TICK_DIVISOR);
  state_t cur, nxt;
  logic ss_p, lap_p, clr_p, run, wrap;
  logic [2:0] unused_levels;
  logic [PW-1:0] presc;
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_stop (
    .clk(clk), .rst(rst), .in(btn_start_stop), .level(unused_levels[0]), .press(ss_p)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk(clk), .rst(rst), .in(btn_lap), .level(unused_levels[1]), .press(lap_p)
  );
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .in(btn_clear), .level(unused_levels[2]), .press(clr_p)
  );
  assign state = cur;
  assign run   = (cur == RUNNING) || (cur == LAP);
  assign wrap  = run && (presc == PW'(TICK_DIVISOR - 1));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  // next state: clear beats start_stop beats lap; lap only matters in RUNNING and LAP
  always_comb begin
    nxt = cur;
    if (clr_p)      nxt = IDLE;
    else if (ss_p)  nxt = run ? PAUSED : RUNNING;
    else if (lap_p) nxt = (cur == RUNNING) ? LAP : (cur == LAP) ? RUNNING : cur;
  end
  // prescaler, tick/clear pulses and display register; the last live value before LAP stays frozen
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc          <= '0;
      count_enable   <= 1'b0;
      count_clear    <= 1'b0;
      display_number <= 16'h0000;
    end else begin
      presc          <= (cur == IDLE || wrap) ? '0 : run ? presc + PW'(1) : presc;
      count_enable   <= wrap;
      count_clear    <= clr_p;
      display_number <= (cur == LAP) ? display_number : number_in;
    end
endmodule

// File: tb/tb_stopwatch_control.sv
// tb_stopwatch_control: scenario tasks with tick/clear scoreboards for stopwatch_control
module tb_stopwatch_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_start_stop = 1'b0;
  logic btn_lap = 1'b0;
  logic btn_clear = 1'b0;
  logic [15:0] number_in = 16'h0000;
  logic count_enable, count_clear;
  logic [15:0] display_number;
  logic [1:0] state;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_ticks = 0;
  bit tick_chk = 0;
  int tick_q[$];
  int clr_q[$];

  stopwatch_control #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(1000),
    .TICK_FREQUENCY_IN_HZ(100),
    .DEBOUNCE_TIME_IN_MS(4)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_start_stop(btn_start_stop), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .number_in(number_in),
    .count_enable(count_enable), .count_clear(count_clear),
    .display_number(display_number), .state(state)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // tick scoreboard: every tick must land on the next expected cycle while checking is on
  always @(negedge clk) begin
    int e;
    if (count_enable) begin
      n_ticks++;
      if (tick_chk) begin
        checks++;
        if (tick_q.size() == 0) begin
          failures++;
          $display("FAIL tick_unexpected got_cycle=%0d expected_none", cyc);
        end else begin
          e = tick_q.pop_front();
          if (cyc !== e) begin
            failures++;
            $display("FAIL tick_cycle got=%0d exp=%0d", cyc, e);
          end
        end
      end
    end
  end

  // clear scoreboard: every count_clear pulse must match a queued expectation
  always @(negedge clk) begin
    int e;
    if (count_clear) begin
      checks++;
      if (clr_q.size() == 0) begin
        failures++;
        $display("FAIL clear_unexpected got_cycle=%0d expected_none", cyc);
      end else begin
        e = clr_q.pop_front();
        if (cyc !== e) begin
          failures++;
          $display("FAIL clear_cycle got=%0d exp=%0d", cyc, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input int b, input logic v);
    case (b)
      0: btn_start_stop = v;
      1: btn_lap = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int b);
    hold(b, 1'b1);
    step(7);
    hold(b, 1'b0);
    step(8);
  endtask

  task automatic chk_state(input string name, input logic [1:0] exp);
    checks++;
    if (state !== exp) begin
      failures++;
      $display("FAIL %s state got=%b exp=%b", name, state, exp);
    end
  endtask

  task automatic chk_disp(input string name, input logic [15:0] exp);
    checks++;
    if (display_number !== exp) begin
      failures++;
      $display("FAIL %s display got=%h exp=%h", name, display_number, exp);
    end
  endtask

  task automatic test_reset();
    number_in = 16'h5A5A;
    step(2);
    chk_state("reset", 2'b00);
    chk_disp("reset", 16'h0000);
    checks++;
    if ({count_enable, count_clear} !== 2'b00) begin
      failures++;
      $display("FAIL reset_pulses got=%b exp=00", {count_enable, count_clear});
    end
    rst = 1'b0;
    step(3);
    chk_state("reset_release", 2'b00);
    chk_disp("reset_release_live", 16'h5A5A);
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 10; i++) begin
      btn_start_stop = (i % 2 == 0);
      step(2);
    end
    chk_state("bounce_ignored", 2'b00);
    btn_start_stop = 1'b1;
    step(6);
    chk_state("debounce_edge_minus1", 2'b00);
    step(1);
    chk_state("debounce_edge", 2'b01);
    step(30);
    chk_state("held_no_repeat", 2'b01);
    btn_start_stop = 1'b0;
    step(8);
    chk_state("release_no_pulse", 2'b01);
  endtask

  task automatic test_ticks();
    int s, n0, r;
    clr_q.push_back(cyc + 7);
    press(2);
    chk_state("clear_to_idle", 2'b00);
    hold(0, 1'b1);
    step(7);
    chk_state("tick_start", 2'b01);
    hold(0, 1'b0);
    s = cyc;
    n0 = n_ticks;
    for (int k = 1; k <= 11; k++) tick_q.push_back(s + 10 * k);
    tick_chk = 1;
    step(101);
    checks++;
    if (n_ticks - n0 !== 10) begin
      failures++;
      $display("FAIL tick_count got=%0d exp=10", n_ticks - n0);
    end
    step(8);
    hold(0, 1'b1);
    step(7);
    chk_state("pause", 2'b10);
    hold(0, 1'b0);
    step(20);
    chk_state("paused_hold", 2'b10);
    checks++;
    if (tick_q.size() !== 0) begin
      failures++;
      $display("FAIL tick_pending_pause got=%0d exp=0", tick_q.size());
    end
    hold(0, 1'b1);
    step(7);
    chk_state("resume", 2'b01);
    r = cyc;
    tick_q.push_back(r + 4);
    tick_q.push_back(r + 14);
    hold(0, 1'b0);
    step(16);
    checks++;
    if (tick_q.size() !== 0) begin
      failures++;
      $display("FAIL tick_pending_resume got=%0d exp=0", tick_q.size());
    end
    tick_chk = 0;
  endtask

  task automatic test_lap();
    int n0;
    number_in = 16'h011D;
    hold(1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(1);
      number_in = number_in + 16'h0001;
    end
    hold(1, 1'b0);
    chk_state("lap_enter", 2'b11);
    chk_disp("lap_capture", 16'h0123);
    n0 = n_ticks;
    for (int i = 0; i < 30; i++) begin
      step(1);
      number_in = number_in + 16'h0001;
      chk_disp("lap_frozen", 16'h0123);
    end
    checks++;
    if (n_ticks - n0 !== 3) begin
      failures++;
      $display("FAIL lap_ticks got=%0d exp=3", n_ticks - n0);
    end
    number_in = 16'h0456;
    hold(1, 1'b1);
    step(7);
    chk_state("lap_leave", 2'b01);
    chk_disp("lap_leave_held", 16'h0123);
    step(1);
    chk_disp("lap_leave_live", 16'h0456);
    hold(1, 1'b0);
    step(8);
  endtask

  task automatic test_priority();
    int bad = 0;
    clr_q.push_back(cyc + 7);
    btn_clear = 1'b1;
    btn_start_stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (state === 2'b10) bad++;
      if (i == 6) chk_state("priority_idle", 2'b00);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL priority_paused_cycles got=%0d exp=0", bad);
    end
    btn_clear = 1'b0;
    btn_start_stop = 1'b0;
    step(8);
    checks++;
    if (clr_q.size() !== 0) begin
      failures++;
      $display("FAIL priority_clear_pending got=%0d exp=0", clr_q.size());
    end
    press(1);
    chk_state("lap_ignored_idle", 2'b00);
  endtask

  task automatic test_reset_mid();
    press(0);
    number_in = 16'h0777;
    press(1);
    chk_state("pre_reset_lap", 2'b11);
    step(3);
    rst = 1'b1;
    #1;
    chk_state("mid_reset", 2'b00);
    chk_disp("mid_reset", 16'h0000);
    checks++;
    if ({count_enable, count_clear} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_pulses got=%b exp=00", {count_enable, count_clear});
    end
    step(2);
    tick_chk = 1;
    rst = 1'b0;
    step(20);
    chk_state("post_reset_idle", 2'b00);
    chk_disp("post_reset_live", 16'h0777);
    hold(0, 1'b1);
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(6);
    chk_state("held_reset_wait", 2'b00);
    step(1);
    chk_state("held_reset_press", 2'b01);
    tick_chk = 0;
    hold(0, 1'b0);
    step(10);
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_debounce();
    test_ticks();
    test_lap();
    test_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
